// File: rtl/snd_mailbox.sv
// snd_mailbox: Z80-side 68k<->Z80 sound command/reply mailbox with edge-triggered NMI.
// Define SND_MAILBOX_OVERRUN_EN to add the CMD_OVERRUN flag.
module snd_mailbox #(
  parameter logic [7:0] CMD_RST_VAL   = 8'h00,
  parameter logic [7:0] REPLY_RST_VAL = 8'h00,
  parameter int         NMI_GAP       = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       M68K_CMD_WE,
  input  logic [7:0] M68K_DIN,
  input  logic       M68K_REPLY_RE,
  output logic [7:0] M68K_REPLY,
  output logic       REPLY_VALID,
  input  logic       Z80_CMD_RE,
  output logic [7:0] Z80_CMD,
  input  logic       Z80_REPLY_WE,
  input  logic [7:0] Z80_DIN,
  input  logic       Z80_NMI_EN,
  output logic       CMD_PENDING,
`ifdef SND_MAILBOX_OVERRUN_EN
  output logic       CMD_OVERRUN,
`endif
  output logic       nZ80NMI
);
  typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;
  localparam logic [3:0] GAP_LD = 4'(NMI_GAP - 1);
  state_t     state, next_state;
  logic [3:0] cnt, next_cnt;
  logic       next_nmi_n;
  logic       rd;
  // A same-cycle 68k write overrides the Z80 acknowledge.
  assign rd = Z80_CMD_RE & ~M68K_CMD_WE;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      Z80_CMD     <= CMD_RST_VAL;
      CMD_PENDING <= 1'b0;
      M68K_REPLY  <= REPLY_RST_VAL;
      REPLY_VALID <= 1'b0;
    end else begin
      if (M68K_CMD_WE) Z80_CMD <= M68K_DIN;
      CMD_PENDING <= M68K_CMD_WE | (CMD_PENDING & ~Z80_CMD_RE);
      if (Z80_REPLY_WE) M68K_REPLY <= Z80_DIN;
      REPLY_VALID <= Z80_REPLY_WE | (REPLY_VALID & ~M68K_REPLY_RE);
    end
`ifdef SND_MAILBOX_OVERRUN_EN
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) CMD_OVERRUN <= 1'b0;
    else CMD_OVERRUN <= (M68K_CMD_WE & CMD_PENDING) | (CMD_OVERRUN & ~rd);
`endif
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      nZ80NMI <= 1'b1;
    end else begin
      state   <= next_state;
      cnt     <= next_cnt;
      nZ80NMI <= next_nmi_n;
    end
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE:
        if (CMD_PENDING & Z80_NMI_EN & ~rd) next_state = ASSERT;
      ASSERT:
        if (M68K_CMD_WE) begin
          next_state = GAP;
          next_cnt   = GAP_LD;
        end else if (Z80_CMD_RE | ~Z80_NMI_EN) next_state = IDLE;
      GAP:
        if (rd) next_state = IDLE;
        else if (cnt == 4'd0) next_state = (CMD_PENDING & Z80_NMI_EN) ? ASSERT : IDLE;
        else next_cnt = cnt - 4'd1;
      default: next_state = IDLE;
    endcase
  end
  always_comb next_nmi_n = (next_state != ASSERT);
endmodule

// File: tb/tb_snd_mailbox.sv
// tb_snd_mailbox: directed self-checking bench for snd_mailbox.
module tb_snd_mailbox;
  logic       CLK = 1'b0, RESET = 1'b1;
  logic       M68K_CMD_WE = 0, M68K_REPLY_RE = 0, Z80_CMD_RE = 0, Z80_REPLY_WE = 0, Z80_NMI_EN = 0;
  logic [7:0] M68K_DIN = 0, Z80_DIN = 0;
  logic [7:0] M68K_REPLY, Z80_CMD;
  logic       REPLY_VALID, CMD_PENDING, nZ80NMI;
`ifdef SND_MAILBOX_OVERRUN_EN
  logic       CMD_OVERRUN;
`endif
  int checks = 0, failures = 0;
  snd_mailbox dut (
    .CLK(CLK), .RESET(RESET),
    .M68K_CMD_WE(M68K_CMD_WE), .M68K_DIN(M68K_DIN),
    .M68K_REPLY_RE(M68K_REPLY_RE), .M68K_REPLY(M68K_REPLY), .REPLY_VALID(REPLY_VALID),
    .Z80_CMD_RE(Z80_CMD_RE), .Z80_CMD(Z80_CMD),
    .Z80_REPLY_WE(Z80_REPLY_WE), .Z80_DIN(Z80_DIN), .Z80_NMI_EN(Z80_NMI_EN),
    .CMD_PENDING(CMD_PENDING),
`ifdef SND_MAILBOX_OVERRUN_EN
    .CMD_OVERRUN(CMD_OVERRUN),
`endif
    .nZ80NMI(nZ80NMI)
  );
  always #5 CLK = ~CLK;
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cmd_write(input logic [7:0] d);
    M68K_DIN = d;
    M68K_CMD_WE = 1;
    tick;
    M68K_CMD_WE = 0;
  endtask
  task automatic z80_read;
    Z80_CMD_RE = 1;
    tick;
    Z80_CMD_RE = 0;
  endtask
  initial begin
    repeat (2) tick;
    RESET = 0;
    tick;
    chk("rst_cmd", Z80_CMD, 8'h00);
    chk("rst_reply", M68K_REPLY, 8'h00);
    chk("rst_pending", 8'(CMD_PENDING), 8'h0);
    chk("rst_valid", 8'(REPLY_VALID), 8'h0);
    chk("rst_nmi", 8'(nZ80NMI), 8'h1);
    // basic command and acknowledge
    Z80_NMI_EN = 1;
    cmd_write(8'h3C);
    chk("cmd_3c", Z80_CMD, 8'h3C);
    chk("pend_3c", 8'(CMD_PENDING), 8'h1);
    chk("nmi_pre", 8'(nZ80NMI), 8'h1);
    tick;
    chk("nmi_low", 8'(nZ80NMI), 8'h0);
    z80_read;
    chk("ack_pend", 8'(CMD_PENDING), 8'h0);
    chk("ack_nmi", 8'(nZ80NMI), 8'h1);
    chk("ack_cmd", Z80_CMD, 8'h3C);
    // overwrite while pending opens a 4-cycle gap
    cmd_write(8'h10);
    tick;
    chk("ow_nmi_low", 8'(nZ80NMI), 8'h0);
    cmd_write(8'h11);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("gap%0d", i), 8'(nZ80NMI), 8'h1);
      tick;
    end
    chk("gap_end", 8'(nZ80NMI), 8'h0);
    chk("ow_cmd", Z80_CMD, 8'h11);
    chk("ow_pend", 8'(CMD_PENDING), 8'h1);
`ifdef SND_MAILBOX_OVERRUN_EN
    chk("ovr_set", 8'(CMD_OVERRUN), 8'h1);
`endif
    z80_read;
    chk("ow_ack_nmi", 8'(nZ80NMI), 8'h1);
`ifdef SND_MAILBOX_OVERRUN_EN
    chk("ovr_clr", 8'(CMD_OVERRUN), 8'h0);
`endif
    // simultaneous write and read from ASSERT: write wins, fresh edge
    cmd_write(8'h20);
    tick;
    chk("sim_nmi_low", 8'(nZ80NMI), 8'h0);
    M68K_DIN = 8'h21;
    M68K_CMD_WE = 1;
    Z80_CMD_RE = 1;
    tick;
    M68K_CMD_WE = 0;
    Z80_CMD_RE = 0;
    chk("sim_pend", 8'(CMD_PENDING), 8'h1);
    chk("sim_cmd", Z80_CMD, 8'h21);
    chk("sim_nmi_gap", 8'(nZ80NMI), 8'h1);
    repeat (4) tick;
    chk("sim_nmi_re", 8'(nZ80NMI), 8'h0);
    // disabling NMI drops it while the command stays pending
    Z80_NMI_EN = 0;
    tick;
    chk("dis_nmi", 8'(nZ80NMI), 8'h1);
    chk("dis_pend", 8'(CMD_PENDING), 8'h1);
    z80_read;
    // command posted with NMI disabled
    cmd_write(8'h55);
    tick;
    chk("en0_nmi", 8'(nZ80NMI), 8'h1);
    chk("en0_pend", 8'(CMD_PENDING), 8'h1);
    Z80_NMI_EN = 1;
    tick;
    chk("en1_nmi", 8'(nZ80NMI), 8'h0);
    z80_read;
    // reply path
    Z80_DIN = 8'hA5;
    Z80_REPLY_WE = 1;
    tick;
    Z80_REPLY_WE = 0;
    chk("rep_valid", 8'(REPLY_VALID), 8'h1);
    chk("rep_a5", M68K_REPLY, 8'hA5);
    Z80_DIN = 8'h5A;
    Z80_REPLY_WE = 1;
    M68K_REPLY_RE = 1;
    tick;
    Z80_REPLY_WE = 0;
    M68K_REPLY_RE = 0;
    chk("rep_wr_wins", 8'(REPLY_VALID), 8'h1);
    chk("rep_5a", M68K_REPLY, 8'h5A);
    M68K_REPLY_RE = 1;
    tick;
    M68K_REPLY_RE = 0;
    chk("rep_read", 8'(REPLY_VALID), 8'h0);
    // asynchronous reset mid-operation
    cmd_write(8'h77);
    tick;
    chk("pre_rst_nmi", 8'(nZ80NMI), 8'h0);
    #2 RESET = 1;
    #1;
    chk("arst_nmi", 8'(nZ80NMI), 8'h1);
    chk("arst_pend", 8'(CMD_PENDING), 8'h0);
    chk("arst_cmd", Z80_CMD, 8'h00);
    chk("arst_reply", M68K_REPLY, 8'h00);
    M68K_DIN = 8'h99;
    M68K_CMD_WE = 1;
    repeat (2) tick;
    chk("hold_pend", 8'(CMD_PENDING), 8'h0);
    chk("hold_cmd", Z80_CMD, 8'h00);
    RESET = 0;
    M68K_CMD_WE = 0;
    tick;
    chk("post_rst_pend", 8'(CMD_PENDING), 8'h0);
    chk("post_rst_nmi", 8'(nZ80NMI), 8'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
